dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the pipeline load/store stage, requester 1 is the loader/debug port.
- Sits between the requesters and the data memory. It owns the memory's address, write-data and write-not-read inputs, and returns read data to the winner.
- Serialises accesses through a 4-state FSM: one memory access in flight at a time, round-robin fairness.

Parameters:
- AW, 16, address width (word addressed)
- DW, 16, data word width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0  in  1  requester 0 access request, level, held until done0
- addr0  in  AW  requester 0 address, stable while req0=1
- wdata0  in  DW  requester 0 write data
- wnotr0  in  1  requester 0: 1=write, 0=read
- gnt0  out  1  requester 0 owns the port (ISSUE/WAIT/DONE)
- done0  out  1  one-cycle pulse: requester 0 access complete
- req1, addr1, wdata1, wnotr1  in  as above, requester 1
- gnt1, done1  out  as above, requester 1
- rdata  out  DW  read data of the completed access, valid while doneN=1
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_wnotr  out  1  memory write enable, qualified by mem_en
- mem_rdata  in  DW  memory read data; registered memory, valid the cycle after the mem_en cycle

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; gnt0/1, done0/1, mem_en, mem_wnotr = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - RR pointer = requester 0 preferred.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If one request, grant it. If both, grant the RR-preferred requester.
  - On the grant edge: latch the winner's addr, wdata and wnotr into mem_addr, mem_wdata, mem_wnotr; set gntN; go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle; memory performs the access at the next edge; go to WAIT.
- WAIT:
  - mem_en=0, gntN held.
  - At the edge: rdata <= mem_rdata if read; rdata unchanged if write. Set doneN=1; go to DONE.
- DONE:
  - doneN=1 for this cycle only. At the edge: clear doneN and gntN; go to IDLE.
  - The RR pointer flips to prefer the non-winner.
  - req inputs are not sampled in DONE, so a requester may drop or re-raise req at the edge ending DONE with no duplicate grant.
- Latency: req seen at IDLE edge E0 -> mem_en during E0..E1 -> done during E2..E3. Back-to-back accesses start every 4 cycles.
- Latched mem_* outputs hold their values through IDLE until the next grant; only mem_en qualifies them.
- A req change while granted is ignored until the next IDLE.
- Loser's req stays pending, unaffected; it wins the next IDLE arbitration under RR.
- Reset during ISSUE: mem_en drops combinationally with reset, so no write reaches memory. The access is abandoned and no done is issued.
- gnt0 and gnt1 are never both 1; done0 and done1 are never both 1.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins simultaneous requests; RR pointer logic is removed. Requester 1 may starve under a continuous req0.
- Undefined: round-robin as described above.

Test Plan:
- Single read: mem[0x0040]=0xBEEF, req1=1, addr1=0x0040, wnotr1=0.
  - mem_en high exactly 1 cycle with mem_addr=0x0040.
  - done1 pulses 3 cycles after the grant edge with rdata=0xBEEF.
  - gnt0 stays 0 throughout.
- Write then read: req0 write addr 0x0010, wdata 0x1234.
  - mem_en with mem_wnotr=1 and mem_wdata=0x1234; done0 pulse.
  - Then req0 read of 0x0010 -> rdata=0x1234.
- Contention: req0 and req1 both held continuously.
  - Grants alternate 0,1,0,1; each done separated by 4 cycles.
  - With ARB_FIXED_PRIO_EN: grants 0,0,0,0.
- Mid-access reset: assert reset=0 during ISSUE of a write of 0xAAAA to 0x0005.
  - mem[0x0005] unchanged; all outputs 0 immediately.
  - After release, IDLE grants the pending request anew.
- No-duplicate: requester 0 drops req0 at the edge ending DONE.
  - No second grant and no second mem_en.
  - Requester 1 raised meanwhile is granted in the next IDLE.
- Idle hold: no requests for 20 cycles -> mem_en=0, gnt0/1=0, mem_addr unchanged from the last access.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: one access in flight,
// round-robin between requesters, or fixed priority to requester 0 when ARB_FIXED_PRIO_EN is defined.
module dm_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          wnotr0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          wnotr1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wnotr,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic [1:0]    gnt_reg, gnt_next;
    logic [1:0]    done_reg, done_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          mem_wnotr_reg, mem_wnotr_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    logic          winner;

    logic [AW-1:0] addr_arr  [2];
    logic [DW-1:0] wdata_arr [2];
    logic [1:0]    wnotr_vec;

    assign addr_arr[0]  = addr0;
    assign addr_arr[1]  = addr1;
    assign wdata_arr[0] = wdata0;
    assign wdata_arr[1] = wdata1;
    assign wnotr_vec    = {wnotr1, wnotr0};

`ifdef ARB_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    // rr_reg holds the index of the requester preferred on a tie.
    logic rr_reg;

    assign winner = (req0 && req1) ? rr_reg : ~req0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            rr_reg <= ~owner_reg;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        gnt_next       = gnt_reg;
        done_next      = done_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wnotr_next = mem_wnotr_reg;
        rdata_next     = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    owner_next         = winner;
                    gnt_next           = 2'b00;
                    gnt_next[winner]   = 1'b1;
                    mem_addr_next      = addr_arr[winner];
                    mem_wdata_next     = wdata_arr[winner];
                    mem_wnotr_next     = wnotr_vec[winner];
                    state_next         = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // Registered memory: read data is valid in the cycle after the strobe.
                if (!mem_wnotr_reg) begin
                    rdata_next = mem_rdata;
                end
                done_next[owner_reg] = 1'b1;
                state_next           = DONE;
            end
            DONE: begin
                gnt_next   = 2'b00;
                done_next  = 2'b00;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wnotr_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wnotr_reg <= mem_wnotr_next;
            rdata_reg     <= rdata_next;
        end
    end

    // Gating with reset kills an in-flight strobe the moment reset asserts.
    assign mem_en    = (state_reg == ISSUE) && reset;
    assign gnt0      = gnt_reg[0];
    assign gnt1      = gnt_reg[1];
    assign done0     = done_reg[0];
    assign done1     = done_reg[1];
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wnotr = mem_wnotr_reg;
    assign rdata     = rdata_reg;

endmodule
